sram_port_arbiter: RTL and testbench

- Sequences the board's external asynchronous 16-bit SRAM, which has 18-bit addressing and byte lanes.
- Shares the SRAM between two on-chip requesters: port 0 is the CPU bus interface; port 1 is a DMA/peripheral master such as a UART buffer.
- Generates the SRCO strobes, drives SRAA, and owns the bidirectional SRDB bus.
- Replaces direct CPU-side strobe generation at the TRIPUTER top level.

---
 rtl/sram_ctl_pkg.sv | 22 ++
 rtl/sram_arb_pick.sv | 50 +++++
 rtl/sram_port_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctl_pkg.sv
// Shared definitions for the external asynchronous SRAM sequencer.
//   state_e   : sequencer states (IDLE, SETUP, ACCESS, END)
//   CE_N..LB_N: bit positions of the active-low strobes inside SRCO
//   SRCO_IDLE : strobe pattern with every strobe deasserted
package sram_ctl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        END
    } state_e;

    localparam int unsigned CE_N = 4;
    localparam int unsigned OE_N = 3;
    localparam int unsigned WE_N = 2;
    localparam int unsigned UB_N = 1;
    localparam int unsigned LB_N = 0;

    localparam logic [4:0] SRCO_IDLE = 5'b11111;

endpackage

// File: rtl/sram_arb_pick.sv
// Two-port grant selection: fixed priority to port 0, with a starvation counter
// that hands the grant to port 1 after STARVE_MAX port-0 wins while port 1 waited.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset
//   req_i   : raw requests, [0]=port 0, [1]=port 1
//   excl_i  : ports excluded from this arbitration (just-served port)
//   grant_i : strobe, a grant is being taken this cycle using gnt_o
//   gnt_o   : index of the port that wins if a grant is taken
module sram_arb_pick #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic [1:0] excl_i,
    input  logic       grant_i,
    output logic       gnt_o
);

    logic [3:0] cnt_q, cnt_d;
    logic [1:0] eff;

    always_comb begin
        eff = req_i & ~excl_i;
        if (eff == 2'b11) begin
            gnt_o = (cnt_q == 4'(STARVE_MAX));
        end else begin
            gnt_o = ~eff[0] & eff[1];
        end

        cnt_d = cnt_q;
        if (grant_i) begin
            // Only a port-0 win while port 1 is genuinely waiting counts toward starvation.
            if (gnt_o || !eff[1]) begin
                cnt_d = 4'd0;
            end else if (cnt_q < 4'(STARVE_MAX)) begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Sequencer for the external asynchronous 16-bit SRAM, shared by two requesters.
//   BCLK, RESET           : clock and synchronous active-high reset
//   P0_* / P1_*           : request ports (REQ held until ACK; fields sampled at grant)
//   P0_ACK / P1_ACK       : one-cycle completion pulse; RDATA valid while ACK=1
//   SRCO                  : active-low strobes {CE_n, OE_n, WE_n, UB_n, LB_n}
//   SRAA                  : SRAM word address
//   SRDB                  : SRAM data, driven only while a write is in flight
// Every SRAM-facing signal comes straight from a flop so the strobes are glitch free.
module sram_port_arbiter
    import sram_ctl_pkg::*;
#(
    parameter int unsigned WAIT_CYC   = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        BCLK,
    input  logic        RESET,
    input  logic        P0_REQ,
    input  logic        P0_WR,
    input  logic [1:0]  P0_BE,
    input  logic [17:0] P0_ADDR,
    input  logic [15:0] P0_WDATA,
    output logic        P0_ACK,
    output logic [15:0] P0_RDATA,
    input  logic        P1_REQ,
    input  logic        P1_WR,
    input  logic [1:0]  P1_BE,
    input  logic [17:0] P1_ADDR,
    input  logic [15:0] P1_WDATA,
    output logic        P1_ACK,
    output logic [15:0] P1_RDATA,
    output logic [4:0]  SRCO,
    output logic [17:0] SRAA,
    inout  wire  [15:0] SRDB
);

    state_e      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic        gnt_q, gnt_d;
    logic        wr_q, wr_d;
    logic [1:0]  be_q, be_d;
    logic [17:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [4:0]  srco_q, srco_d;
    logic [17:0] sraa_q, sraa_d;
    logic        srdb_oe_q, srdb_oe_d;
    logic [1:0]  ack_q, ack_d;
    logic [15:0] rdata0_q, rdata0_d;
    logic [15:0] rdata1_q, rdata1_d;

    logic [1:0]  excl;
    logic        any_req;
    logic        grant;
    logic        pick;
    logic        sel_wr;
    logic [1:0]  sel_be;
    logic [17:0] sel_addr;
    logic [15:0] sel_wdata;

    // In END the served port still holds REQ high, so it must not win again.
    always_comb begin
        excl = 2'b00;
        if (state_q == END) begin
            excl = gnt_q ? 2'b10 : 2'b01;
        end
        any_req   = |({P1_REQ, P0_REQ} & ~excl);
        grant     = ((state_q == IDLE) || (state_q == END)) && any_req;
        sel_wr    = pick ? P1_WR    : P0_WR;
        sel_be    = pick ? P1_BE    : P0_BE;
        sel_addr  = pick ? P1_ADDR  : P0_ADDR;
        sel_wdata = pick ? P1_WDATA : P0_WDATA;
    end

    sram_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk_i   (BCLK),
        .rst_i   (RESET),
        .req_i   ({P1_REQ, P0_REQ}),
        .excl_i  (excl),
        .grant_i (grant),
        .gnt_o   (pick)
    );

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        gnt_d     = gnt_q;
        wr_d      = wr_q;
        be_d      = be_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        srco_d    = srco_q;
        sraa_d    = sraa_q;
        srdb_oe_d = srdb_oe_q;
        ack_d     = 2'b00;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;

        unique case (state_q)
            IDLE, END: begin
                if (grant) begin
                    state_d   = SETUP;
                    gnt_d     = pick;
                    wr_d      = sel_wr;
                    be_d      = sel_be;
                    addr_d    = sel_addr;
                    wdata_d   = sel_wdata;
                    srco_d    = {1'b0, 1'b1, 1'b1, ~sel_be};
                    sraa_d    = sel_addr;
                    srdb_oe_d = sel_wr;
                end else begin
                    state_d   = IDLE;
                    srco_d    = SRCO_IDLE;
                    srdb_oe_d = 1'b0;
                end
            end
            SETUP: begin
                state_d      = ACCESS;
                wait_d       = 4'(WAIT_CYC);
                srco_d[OE_N] = wr_q;
                srco_d[WE_N] = ~wr_q;
            end
            ACCESS: begin
                if (wait_q <= 4'd1) begin
                    state_d      = END;
                    srco_d[OE_N] = 1'b1;
                    srco_d[WE_N] = 1'b1;
                    ack_d[gnt_q] = 1'b1;
                    // Capture at the edge that closes the last OE_n-low cycle.
                    if (!wr_q) begin
                        if (gnt_q) begin
                            rdata1_d = SRDB;
                        end else begin
                            rdata0_d = SRDB;
                        end
                    end
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge BCLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            wait_q    <= 4'd0;
            gnt_q     <= 1'b0;
            wr_q      <= 1'b0;
            be_q      <= 2'b00;
            addr_q    <= 18'd0;
            wdata_q   <= 16'd0;
            srco_q    <= SRCO_IDLE;
            sraa_q    <= 18'd0;
            srdb_oe_q <= 1'b0;
            ack_q     <= 2'b00;
            rdata0_q  <= 16'd0;
            rdata1_q  <= 16'd0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            gnt_q     <= gnt_d;
            wr_q      <= wr_d;
            be_q      <= be_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            srco_q    <= srco_d;
            sraa_q    <= sraa_d;
            srdb_oe_q <= srdb_oe_d;
            ack_q     <= ack_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign SRCO     = srco_q;
    assign SRAA     = sraa_q;
    assign SRDB     = srdb_oe_q ? wdata_q : 16'hzzzz;
    assign P0_ACK   = ack_q[0];
    assign P1_ACK   = ack_q[1];
    assign P0_RDATA = rdata0_q;
    assign P1_RDATA = rdata1_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural asynchronous SRAM model.
module tb_sram_port_arbiter;

    logic        BCLK = 1'b0;
    logic        RESET;
    logic        P0_REQ, P0_WR, P1_REQ, P1_WR;
    logic [1:0]  P0_BE, P1_BE;
    logic [17:0] P0_ADDR, P1_ADDR;
    logic [15:0] P0_WDATA, P1_WDATA;
    logic        P0_ACK, P1_ACK;
    logic [15:0] P0_RDATA, P1_RDATA;
    logic [4:0]  SRCO;
    logic [17:0] SRAA;
    wire  [15:0] srdb;

    int checks = 0;
    int failures = 0;

    logic [15:0] mem [0:255];

    always #5 BCLK = ~BCLK;

    sram_port_arbiter dut (
        .BCLK     (BCLK),
        .RESET    (RESET),
        .P0_REQ   (P0_REQ),
        .P0_WR    (P0_WR),
        .P0_BE    (P0_BE),
        .P0_ADDR  (P0_ADDR),
        .P0_WDATA (P0_WDATA),
        .P0_ACK   (P0_ACK),
        .P0_RDATA (P0_RDATA),
        .P1_REQ   (P1_REQ),
        .P1_WR    (P1_WR),
        .P1_BE    (P1_BE),
        .P1_ADDR  (P1_ADDR),
        .P1_WDATA (P1_WDATA),
        .P1_ACK   (P1_ACK),
        .P1_RDATA (P1_RDATA),
        .SRCO     (SRCO),
        .SRAA     (SRAA),
        .SRDB     (srdb)
    );

    // SRAM model: drives data while CE_n=0, OE_n=0, WE_n=1; writes lanes while WE_n=0.
    assign srdb = (!SRCO[4] && !SRCO[3] && SRCO[2]) ? mem[SRAA[7:0]] : 16'hzzzz;

    always @(posedge BCLK) begin
        if (!SRCO[4] && !SRCO[2]) begin
            if (!SRCO[1]) mem[SRAA[7:0]][15:8] <= srdb[15:8];
            if (!SRCO[0]) mem[SRAA[7:0]][7:0]  <= srdb[7:0];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // The DUT must never drive SRDB while the SRAM has its output enabled.
    always @(negedge BCLK) begin
        if (!RESET) begin
            check("bus_contention", {31'd0, dut.srdb_oe_q & ~SRCO[3]}, 32'd0);
        end
    end

    task automatic set_port(input int port, input logic wr, input logic [1:0] be,
                            input logic [17:0] addr, input logic [15:0] wd);
        if (port == 0) begin
            P0_WR = wr; P0_BE = be; P0_ADDR = addr; P0_WDATA = wd; P0_REQ = 1'b1;
        end else begin
            P1_WR = wr; P1_BE = be; P1_ADDR = addr; P1_WDATA = wd; P1_REQ = 1'b1;
        end
    endtask

    // Single access from one port; returns ACK latency and strobe-low cycle counts.
    task automatic do_access(input int port, input logic wr, input logic [1:0] be,
                             input logic [17:0] addr, input logic [15:0] wd,
                             output int lat, output int oe_cyc, output int we_cyc);
        lat = 0; oe_cyc = 0; we_cyc = 0;
        set_port(port, wr, be, addr, wd);
        while (lat < 40) begin
            @(negedge BCLK);
            lat++;
            if (!SRCO[3]) oe_cyc++;
            if (!SRCO[2]) we_cyc++;
            if ((port == 0 && P0_ACK) || (port == 1 && P1_ACK)) break;
        end
        if (port == 0) P0_REQ = 1'b0; else P1_REQ = 1'b0;
        @(negedge BCLK);
    endtask

    int lat, oe_c, we_c, n, cyc;
    int order [6];
    int t_ack [6];
    int t0, t1;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        RESET = 1'b1;
        P0_REQ = 0; P0_WR = 0; P0_BE = 0; P0_ADDR = 0; P0_WDATA = 0;
        P1_REQ = 0; P1_WR = 0; P1_BE = 0; P1_ADDR = 0; P1_WDATA = 0;
        repeat (2) @(negedge BCLK);
        check("rst_srco", SRCO, 5'b11111);
        check("rst_sraa", SRAA, 18'd0);
        check("rst_oe", dut.srdb_oe_q, 1'b0);
        check("rst_acks", {P1_ACK, P0_ACK}, 2'b00);
        check("rst_rdata", {P1_RDATA, P0_RDATA}, 32'd0);
        RESET = 1'b0;
        @(negedge BCLK);

        // First write, cycle by cycle.
        set_port(0, 1'b1, 2'b11, 18'h00010, 16'hA5C3);
        @(negedge BCLK);
        check("wr_c1_srco", SRCO, 5'b01100);
        check("wr_c1_sraa", SRAA, 18'h00010);
        check("wr_c1_srdb", srdb, 16'hA5C3);
        check("wr_c1_oe", dut.srdb_oe_q, 1'b1);
        @(negedge BCLK);
        check("wr_c2_srco", SRCO, 5'b01000);
        check("wr_c2_ack", P0_ACK, 1'b0);
        @(negedge BCLK);
        check("wr_c3_srco", SRCO, 5'b01100);
        check("wr_c3_ack", P0_ACK, 1'b1);
        check("wr_c3_srdb", srdb, 16'hA5C3);
        P0_REQ = 1'b0;
        @(negedge BCLK);
        check("wr_c4_srco", SRCO, 5'b11111);
        check("wr_c4_oe", dut.srdb_oe_q, 1'b0);
        check("wr_c4_ack", P0_ACK, 1'b0);
        check("wr_mem", mem[8'h10], 16'hA5C3);

        // Reads and byte-lane writes.
        do_access(0, 1'b0, 2'b11, 18'h00010, 16'h0000, lat, oe_c, we_c);
        check("rd_lat", lat, 3);
        check("rd_oe_cycles", oe_c, 1);
        check("rd_we_cycles", we_c, 0);
        check("rd_data", P0_RDATA, 16'hA5C3);
        do_access(0, 1'b1, 2'b10, 18'h00010, 16'h1234, lat, oe_c, we_c);
        check("be10_lat", lat, 3);
        do_access(0, 1'b0, 2'b11, 18'h00010, 16'h0000, lat, oe_c, we_c);
        check("be10_rd", P0_RDATA, 16'h12C3);
        do_access(0, 1'b1, 2'b00, 18'h00010, 16'hFFFF, lat, oe_c, we_c);
        check("be00_ack_lat", lat, 3);
        check("be00_mem", mem[8'h10], 16'h12C3);
        do_access(0, 1'b0, 2'b11, 18'h00010, 16'h0000, lat, oe_c, we_c);
        check("be00_rd", P0_RDATA, 16'h12C3);

        // Both ports requesting continuously: alternate with no idle gap.
        set_port(0, 1'b0, 2'b11, 18'h00010, 16'h0000);
        set_port(1, 1'b0, 2'b11, 18'h00061, 16'h0000);
        n = 0; cyc = 0;
        while (n < 6 && cyc < 100) begin
            @(negedge BCLK);
            cyc++;
            if (P0_ACK) begin order[n] = 0; t_ack[n] = cyc; n++; end
            if (P1_ACK && n < 6) begin order[n] = 1; t_ack[n] = cyc; n++; end
        end
        P0_REQ = 1'b0; P1_REQ = 1'b0;
        check("cont_count", n, 6);
        check("cont_first_ack", t_ack[0], 3);
        for (int i = 1; i < 6; i++) begin
            check("cont_order", order[i], i % 2);
            check("cont_spacing", t_ack[i] - t_ack[i-1], 3);
        end
        @(negedge BCLK);
        @(negedge BCLK);

        // Starvation: port 1 loses four times (then withdraws), wins the fifth.
        for (int r = 0; r < 6; r++) begin
            set_port(0, 1'b0, 2'b11, 18'h00010, 16'h0000);
            set_port(1, 1'b0, 2'b11, 18'h00030, 16'h0000);
            @(negedge BCLK);
            check("starve_grant", SRAA, (r == 4) ? 18'h00030 : 18'h00010);
            if (r == 4) P0_REQ = 1'b0; else P1_REQ = 1'b0;
            cyc = 0;
            while (!(P0_ACK || P1_ACK) && cyc < 20) begin
                @(negedge BCLK);
                cyc++;
            end
            check("starve_ack_lat", cyc, 2);
            P0_REQ = 1'b0; P1_REQ = 1'b0;
            @(negedge BCLK);
        end

        // Write on port 0 then read on port 1, back to back.
        set_port(0, 1'b1, 2'b11, 18'h00040, 16'hBEEF);
        set_port(1, 1'b0, 2'b11, 18'h00040, 16'h0000);
        t0 = 0; t1 = 0; cyc = 0;
        while (t1 == 0 && cyc < 30) begin
            @(negedge BCLK);
            cyc++;
            if (P0_ACK) begin t0 = cyc; P0_REQ = 1'b0; end
            if (P1_ACK) begin t1 = cyc; P1_REQ = 1'b0; end
        end
        check("b2b_p0_ack", t0, 3);
        check("b2b_p1_ack", t1, 6);
        check("b2b_p1_rdata", P1_RDATA, 16'hBEEF);
        check("b2b_p0_hold", P0_RDATA, 16'h12C3);
        @(negedge BCLK);

        // Reset in the middle of a write, request left pending.
        set_port(0, 1'b1, 2'b11, 18'h00050, 16'h5555);
        @(negedge BCLK);
        @(negedge BCLK);
        check("rst_mid_access", SRCO, 5'b01000);
        RESET = 1'b1;
        @(negedge BCLK);
        check("rst_mid_srco", SRCO, 5'b11111);
        check("rst_mid_oe", dut.srdb_oe_q, 1'b0);
        check("rst_mid_ack", P0_ACK, 1'b0);
        check("rst_mid_rdata", P0_RDATA, 16'h0000);
        RESET = 1'b0;
        do_access(0, 1'b1, 2'b11, 18'h00050, 16'h5555, lat, oe_c, we_c);
        check("rst_pending_lat", lat, 3);
        do_access(0, 1'b0, 2'b11, 18'h00050, 16'h0000, lat, oe_c, we_c);
        check("rst_pending_rd", P0_RDATA, 16'h5555);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
